keypad_scanner: RTL and testbench

//  4x4 matrix-keypad peripheral in the keyboard window of the data bus (0xFFFFF010..0xFFFFF05F).
//  - Scans the rows, synchronises and debounces the columns, and latches a 4-bit key code.
//  - Returns STATUS/KEYCODE words on the combinational read path, which is muxed into rdata beside DRAM and bo.
//  - The bus decoder drives kb_sel; this block owns all keypad pin timing.

---
 rtl/keypad_scanner.sv | 174 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with column synchroniser, debounce FSM and
// a STATUS/KEYCODE register pair on the combinational bus read path.
module keypad_scanner #(
    parameter int unsigned SCAN_CYCLES = 50000,
    parameter int unsigned DEB_CYCLES  = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        kb_sel,
    input  logic        kb_we,
    input  logic [3:0]  kb_addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [3:0]  row_o,
    input  logic [3:0]  col_i,
    output logic        key_irq
);

    localparam int unsigned SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      row_idx_q, row_idx_d;
    logic [3:0]      row_q, row_d;
    logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
    logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
    logic [3:0]      snap_q, snap_d;
    logic [3:0]      code_q, code_d;
    logic            valid_q, valid_d;
    logic            overrun_q, overrun_d;
    logic [3:0]      sync1_q, col_s_q;

    logic            pressed;
    logic            latch;
    logic            advance;
    logic [1:0]      low_col;
    logic            rd_clr;
    logic            ov_clr;
    logic            unused_wdata;

    assign unused_wdata = ^{wdata[31:2], wdata[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_SCAN;
            row_idx_q  <= 2'd0;
            row_q      <= 4'b1110;
            scan_cnt_q <= '0;
            deb_cnt_q  <= '0;
            snap_q     <= '1;
            code_q     <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            sync1_q    <= '1;
            col_s_q    <= '1;
        end else begin
            state_q    <= state_d;
            row_idx_q  <= row_idx_d;
            row_q      <= row_d;
            scan_cnt_q <= scan_cnt_d;
            deb_cnt_q  <= deb_cnt_d;
            snap_q     <= snap_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            sync1_q    <= col_i;
            col_s_q    <= sync1_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_idx_d  = row_idx_q;
        row_d      = row_q;
        scan_cnt_d = scan_cnt_q;
        deb_cnt_d  = deb_cnt_q;
        snap_d     = snap_q;
        code_d     = code_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;
        latch      = 1'b0;
        advance    = 1'b0;
        pressed    = (col_s_q != 4'hF);
        rd_clr     = kb_sel & ~kb_we & (kb_addr == 4'd1);
        ov_clr     = kb_sel & kb_we & (kb_addr == 4'd0) & wdata[1];

        // Scanning from column 3 down leaves the lowest low column in low_col.
        low_col = 2'd0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!snap_q[3-i]) low_col = 2'(3 - i);
        end

        case (state_q)
            ST_SCAN: begin
                if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    if (pressed) begin
                        snap_d    = col_s_q;
                        deb_cnt_d = '0;
                        state_d   = ST_DEBOUNCE;
                    end else begin
                        advance = 1'b1;
                    end
                end else if (scan_cnt_q != '1) begin
                    scan_cnt_d = scan_cnt_q + 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (col_s_q != snap_q) begin
                    state_d    = ST_SCAN;
                    scan_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    latch     = 1'b1;
                    deb_cnt_d = '0;
                    state_d   = ST_RELEASE;
                end else if (deb_cnt_q != '1) begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (pressed) begin
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    deb_cnt_d  = '0;
                    scan_cnt_d = '0;
                    advance    = 1'b1;
                    state_d    = ST_SCAN;
                end else if (deb_cnt_q != '1) begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_SCAN;
            end
        endcase

        if (advance) begin
            row_idx_d = row_idx_q + 2'd1;
            row_d     = {row_q[2:0], row_q[3]};
        end

        if (rd_clr) valid_d = 1'b0;
        if (ov_clr) overrun_d = 1'b0;
        // A latch overrides a same-edge read clear and then does not count as overrun.
        if (latch) begin
            valid_d = 1'b1;
            code_d  = {row_idx_q, low_col};
            if (valid_q && !rd_clr) overrun_d = 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        if (kb_sel) begin
            case (kb_addr)
                4'd0:    rdata = {30'b0, overrun_q, valid_q};
                4'd1:    rdata = {27'b0, valid_q, code_q};
                default: rdata = '0;
            endcase
        end
    end

    assign row_o   = row_q;
    assign key_irq = valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;

    logic        clk;
    logic        rst;
    logic        kb_sel;
    logic        kb_we;
    logic [3:0]  kb_addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  row_o;
    logic [3:0]  col_i;
    logic        key_irq;
    logic [15:0] keys;

    int n_checks;
    int n_errors;

    keypad_scanner #(
        .SCAN_CYCLES(4),
        .DEB_CYCLES (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .kb_sel (kb_sel),
        .kb_we  (kb_we),
        .kb_addr(kb_addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .row_o  (row_o),
        .col_i  (col_i),
        .key_irq(key_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key index = row*4 + col; a held key pulls its column low while its row is driven.
    always_comb begin
        col_i = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row_o[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (keys[r*4+c]) col_i[c] = 1'b0;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic peek_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        kb_sel  = 1'b1;
        kb_we   = 1'b0;
        kb_addr = addr;
        #1;
        check_eq(tag, rdata, exp);
        kb_sel  = 1'b0;
        kb_addr = 4'd0;
    endtask

    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
        kb_sel  = 1'b1;
        kb_we   = 1'b1;
        kb_addr = addr;
        wdata   = data;
        @(negedge clk);
        kb_sel  = 1'b0;
        kb_we   = 1'b0;
        kb_addr = 4'd0;
        wdata   = '0;
    endtask

    task automatic hold_key(input int k);
        keys = 16'(1 << k);
        repeat (40) @(negedge clk);
        keys = '0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        logic [3:0] r0;
        logic       changed;

        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        kb_sel   = 1'b0;
        kb_we    = 1'b0;
        kb_addr  = 4'd0;
        wdata    = '0;
        keys     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check_eq("rst_row", 32'(row_o), 32'h0000000E);
        check_eq("rst_irq", 32'(key_irq), 32'h0);
        peek_check("rst_status", 4'd0, 32'h0);
        peek_check("rst_keycode", 4'd1, 32'h0);

        // Clean press on row 2 / column 1.
        keys = 16'(1 << 9);
        repeat (40) @(negedge clk);
        kb_sel  = 1'b1;
        kb_addr = 4'd1;
        #1;
        check_eq("t2_keycode", rdata, 32'h19);
        check_eq("t2_irq", 32'(key_irq), 32'h1);
        @(negedge clk);
        #1;
        check_eq("t2_keycode_cleared", rdata, 32'h09);
        check_eq("t2_irq_cleared", 32'(key_irq), 32'h0);
        kb_sel = 1'b0;
        #1;
        check_eq("t2_unselected", rdata, 32'h0);
        kb_addr = 4'd0;
        keys = '0;
        repeat (20) @(negedge clk);

        // Bouncing key on row 0 / column 0.
        for (int i = 0; i < 20; i++) begin
            keys = keys ^ 16'h0001;
            repeat (3) @(negedge clk);
        end
        keys = '0;
        repeat (20) @(negedge clk);
        peek_check("t3_status", 4'd0, 32'h0);
        peek_check("t3_keycode", 4'd1, 32'h09);
        r0 = row_o;
        changed = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (row_o != r0) changed = 1'b1;
        end
        check_eq("t3_scan_moves", 32'(changed), 32'h1);

        // Two keys without an intervening read.
        hold_key(5);
        hold_key(14);
        peek_check("t4_status", 4'd0, 32'h3);
        peek_check("t4_keycode", 4'd1, 32'h1E);
        peek_check("t4_unmapped", 4'd5, 32'h0);
        bus_write(4'd0, 32'h1);
        peek_check("t4_store_bit0", 4'd0, 32'h3);
        bus_write(4'd1, 32'h2);
        peek_check("t4_store_addr1", 4'd0, 32'h3);
        bus_write(4'd0, 32'h2);
        peek_check("t4_store_clear", 4'd0, 32'h1);

        // Release bounce: key on row 1 / column 3.
        kb_sel  = 1'b1;
        kb_addr = 4'd1;
        @(negedge clk);
        kb_sel  = 1'b0;
        kb_addr = 4'd0;
        keys = 16'(1 << 7);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (key_irq) break;
        end
        check_eq("t6_latch_seen", 32'(key_irq), 32'h1);
        repeat (5) @(negedge clk);
        check_eq("t6_row_held", 32'(row_o), 32'h0000000D);
        peek_check("t6_keycode", 4'd1, 32'h17);
        keys = '0;
        repeat (3) @(negedge clk);
        keys = 16'(1 << 7);
        repeat (2) @(negedge clk);
        keys = '0;
        repeat (9) @(negedge clk);
        check_eq("t6_row_after_bounce", 32'(row_o), 32'h0000000D);
        @(negedge clk);
        check_eq("t6_row_advanced", 32'(row_o), 32'h0000000B);

        // Read clear aligned with latch edges; key 2 latches 12 edges after reset.
        keys = 16'(1 << 2);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        peek_check("t5_before_latch", 4'd1, 32'h0);
        @(negedge clk);
        kb_sel  = 1'b1;
        kb_addr = 4'd1;
        #1;
        check_eq("t5_read_pre", rdata, 32'h0);
        @(negedge clk);
        #1;
        check_eq("t5_latch_wins", rdata, 32'h12);
        kb_sel  = 1'b0;
        kb_addr = 4'd0;
        keys = 16'(1 << 6);
        repeat (9) @(negedge clk);
        check_eq("t5_release_hold", 32'(row_o), 32'h0000000E);
        @(negedge clk);
        check_eq("t5_release_adv", 32'(row_o), 32'h0000000D);
        repeat (11) @(negedge clk);
        kb_sel  = 1'b1;
        kb_addr = 4'd1;
        #1;
        check_eq("t5_read_pre2", rdata, 32'h12);
        @(negedge clk);
        #1;
        check_eq("t5_collision_code", rdata, 32'h16);
        kb_addr = 4'd0;
        #1;
        check_eq("t5_collision_status", rdata, 32'h1);
        kb_sel = 1'b0;
        keys = 16'(1 << 9);

        // Reset while the row-2 key is mid-debounce.
        repeat (15) @(negedge clk);
        check_eq("t1_pre_row", 32'(row_o), 32'h0000000B);
        peek_check("t1_pre_keycode", 4'd1, 32'h16);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("t1_row", 32'(row_o), 32'h0000000E);
        check_eq("t1_irq", 32'(key_irq), 32'h0);
        peek_check("t1_status", 4'd0, 32'h0);
        peek_check("t1_keycode", 4'd1, 32'h0);
        keys = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        peek_check("t1_discarded", 4'd1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
